// File: rtl/isa_fetch_pkg.sv
// Shared definitions for the ISA fetcher: state encodings and default widths.
package isa_fetch_pkg;

    localparam int PORT_WIDTH   = 128;
    localparam int OPCODE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } isfState_t;

endpackage

// File: rtl/isa_fetch_fifo.sv
// First-word-fall-through FIFO: registered write, head word visible combinationally.
module FIFO_FWFT #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Reset,
    input  logic                  Push,
    input  logic                  Pop,
    input  logic [DATA_WIDTH-1:0] DatIn,
    output logic [DATA_WIDTH-1:0] DatOut,
    output logic                  Empty,
    output logic                  Full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wrPtr;
    logic [ADDR_WIDTH:0]   rdPtr;
    logic                  wrEn;
    logic                  rdEn;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign Empty  = (wrPtr == rdPtr);
    assign Full   = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                    (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
    assign wrEn   = Push & !Full;
    assign rdEn   = Pop & !Empty;
    assign DatOut = mem[rdPtr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + (ADDR_WIDTH+1)'(1);
            if (rdEn) rdPtr <= rdPtr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr[ADDR_WIDTH-1:0]] <= DatIn;
    end

endmodule

// File: rtl/isa_fetch.sv
// ISA word fetcher: credit-limited read requests, buffered in-order stream to the CCU.
// state | meaning
// IDLE  | waiting for start pulse
// FETCH | issuing read requests while buffer credit remains
// DRAIN | all requests issued, waiting for CCU to pop the rest
// DONE  | one-cycle completion pulse
module isa_fetch #(
    parameter int PORT_WIDTH      = isa_fetch_pkg::PORT_WIDTH,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUM_WORD_WIDTH  = 20,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       TOPISF_Start,
    input  logic [DRAM_ADDR_WIDTH-1:0] TOPISF_BaseAddr,
    input  logic [NUM_WORD_WIDTH-1:0]  TOPISF_NumWord,
    output logic                       ISFTOP_Busy,
    output logic                       ISFTOP_Done,
    output logic [DRAM_ADDR_WIDTH-1:0] ISFITF_RdAddr,
    output logic                       ISFITF_RdAddrVld,
    input  logic                       ITFISF_RdAddrRdy,
    input  logic [PORT_WIDTH-1:0]      ITFISF_RdDat,
    input  logic                       ITFISF_RdDatVld,
    output logic                       ISFITF_RdDatRdy,
    output logic [PORT_WIDTH-1:0]      ISFCCU_ISARdDat,
    output logic                       ISFCCU_ISARdDatVld,
    input  logic                       CCUISF_ISARdDatRdy
);

    import isa_fetch_pkg::*;

    localparam logic [FIFO_ADDR_WIDTH:0] CREDIT_MAX = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

    isfState_t                  state;
    isfState_t                  stateNxt;
    logic [DRAM_ADDR_WIDTH-1:0] addrQ;
    logic [NUM_WORD_WIDTH-1:0]  numQ;
    logic [NUM_WORD_WIDTH-1:0]  reqCnt;
    logic [NUM_WORD_WIDTH-1:0]  outCnt;
    logic [FIFO_ADDR_WIDTH:0]   credit;
    logic                       fifoEmpty;
    logic                       fifoFull;
    logic                       reqHs;
    logic                       popHs;
    logic                       lastReq;

    assign ISFITF_RdAddr      = addrQ;
    assign ISFITF_RdDatRdy    = !fifoFull;
    assign ISFCCU_ISARdDatVld = !fifoEmpty;
    assign reqHs              = ISFITF_RdAddrVld & ITFISF_RdAddrRdy;
    assign popHs              = ISFCCU_ISARdDatVld & CCUISF_ISARdDatRdy;
    assign lastReq            = (reqCnt == numQ - NUM_WORD_WIDTH'(1));

    FIFO_FWFT #(
        .DATA_WIDTH (PORT_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) uIsaFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .Reset  (1'b0),
        .Push   (ITFISF_RdDatVld & ISFITF_RdDatRdy),
        .Pop    (popHs),
        .DatIn  (ITFISF_RdDat),
        .DatOut (ISFCCU_ISARdDat),
        .Empty  (fifoEmpty),
        .Full   (fifoFull)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt         = state;
        ISFITF_RdAddrVld = 1'b0;
        ISFTOP_Busy      = 1'b0;
        ISFTOP_Done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (TOPISF_Start) stateNxt = (TOPISF_NumWord != '0) ? FETCH : DONE;
            end
            FETCH: begin
                ISFTOP_Busy      = 1'b1;
                // Only request what the buffer is guaranteed to hold once returned.
                ISFITF_RdAddrVld = (credit < CREDIT_MAX);
                if (ISFITF_RdAddrVld && ITFISF_RdAddrRdy && lastReq) stateNxt = DRAIN;
            end
            DRAIN: begin
                ISFTOP_Busy = 1'b1;
                if (outCnt == numQ) stateNxt = DONE;
            end
            DONE: begin
                ISFTOP_Busy = 1'b1;
                ISFTOP_Done = 1'b1;
                stateNxt    = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrQ  <= '0;
            numQ   <= '0;
            reqCnt <= '0;
            outCnt <= '0;
            credit <= '0;
        end else if (state == IDLE) begin
            if (TOPISF_Start) begin
                addrQ  <= TOPISF_BaseAddr;
                numQ   <= TOPISF_NumWord;
                reqCnt <= '0;
                outCnt <= '0;
                credit <= '0;
            end
        end else begin
            if (reqHs) begin
                addrQ  <= addrQ + DRAM_ADDR_WIDTH'(1);
                reqCnt <= reqCnt + NUM_WORD_WIDTH'(1);
            end
            if (popHs) outCnt <= outCnt + NUM_WORD_WIDTH'(1);
            if (reqHs && !popHs)      credit <= credit + (FIFO_ADDR_WIDTH+1)'(1);
            else if (!reqHs && popHs) credit <= credit - (FIFO_ADDR_WIDTH+1)'(1);
        end
    end

endmodule

// File: tb/tb_isa_fetch.sv
// Bench for isa_fetch: table of fetch jobs against an interface/CCU model with a word scoreboard.
module tb_isa_fetch;

    localparam int PW = 128;
    localparam int AW = 32;
    localparam int NW = 20;
    localparam int FA = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          TOPISF_Start;
    logic [AW-1:0] TOPISF_BaseAddr;
    logic [NW-1:0] TOPISF_NumWord;
    logic          ISFTOP_Busy;
    logic          ISFTOP_Done;
    logic [AW-1:0] ISFITF_RdAddr;
    logic          ISFITF_RdAddrVld;
    logic          ITFISF_RdAddrRdy;
    logic [PW-1:0] ITFISF_RdDat;
    logic          ITFISF_RdDatVld;
    logic          ISFITF_RdDatRdy;
    logic [PW-1:0] ISFCCU_ISARdDat;
    logic          ISFCCU_ISARdDatVld;
    logic          CCUISF_ISARdDatRdy;

    always #5 clk = ~clk;

    isa_fetch #(
        .PORT_WIDTH      (PW),
        .DRAM_ADDR_WIDTH (AW),
        .NUM_WORD_WIDTH  (NW),
        .FIFO_ADDR_WIDTH (FA)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .TOPISF_Start       (TOPISF_Start),
        .TOPISF_BaseAddr    (TOPISF_BaseAddr),
        .TOPISF_NumWord     (TOPISF_NumWord),
        .ISFTOP_Busy        (ISFTOP_Busy),
        .ISFTOP_Done        (ISFTOP_Done),
        .ISFITF_RdAddr      (ISFITF_RdAddr),
        .ISFITF_RdAddrVld   (ISFITF_RdAddrVld),
        .ITFISF_RdAddrRdy   (ITFISF_RdAddrRdy),
        .ITFISF_RdDat       (ITFISF_RdDat),
        .ITFISF_RdDatVld    (ITFISF_RdDatVld),
        .ISFITF_RdDatRdy    (ISFITF_RdDatRdy),
        .ISFCCU_ISARdDat    (ISFCCU_ISARdDat),
        .ISFCCU_ISARdDatVld (ISFCCU_ISARdDatVld),
        .CCUISF_ISARdDatRdy (CCUISF_ISARdDatRdy)
    );

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            pA;
        int            pC;
        int            lat;
        bit            noise;
    } job_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    req_t          pend[$];
    logic [PW-1:0] expQ[$];
    job_t          jobs[6];

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            pA = 100, pC = 100, lat = 2;
    bit            noise = 1'b0;
    bit            startNext = 1'b0;
    logic [AW-1:0] startBase = '0;
    logic [NW-1:0] startNum = '0;
    bit            modelIdle = 1'b1;
    logic [AW-1:0] expAddr = '0;
    int            reqSeen = 0, popSeen = 0, jobNum = 0;
    int            startCyc = 0, firstReqCyc = -1, firstPopCyc = -1, lastPopCyc = 0, doneCyc = 0;
    bit            doneSeen = 1'b0;
    bit            prevStall = 1'b0;
    logic [AW-1:0] prevAddr = '0;

    function automatic logic [PW-1:0] wordOf(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_C3C3, a + 32'h1234_0000};
    endfunction

    task automatic chkD(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkI(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the edge, evaluate handshakes before the next edge.
    task automatic step();
        bit wasIdle;
        @(posedge clk);
        #1;
        cyc++;
        ITFISF_RdAddrRdy   = ($urandom_range(99) < pA);
        CCUISF_ISARdDatRdy = ($urandom_range(99) < pC);
        TOPISF_Start       = startNext;
        TOPISF_BaseAddr    = startBase;
        TOPISF_NumWord     = startNum;
        startNext          = 1'b0;
        if (noise && !modelIdle && $urandom_range(7) == 0) begin
            TOPISF_Start    = 1'b1;
            TOPISF_BaseAddr = $urandom;
            TOPISF_NumWord  = NW'($urandom_range(30, 1));
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ITFISF_RdDatVld = 1'b1;
            ITFISF_RdDat    = wordOf(pend[0].addr);
        end else begin
            ITFISF_RdDatVld = 1'b0;
            ITFISF_RdDat    = '0;
        end
        #1;
        wasIdle = modelIdle;
        chkI("busy", int'(ISFTOP_Busy), int'(!modelIdle));
        if (prevStall) begin
            chkI("addrHoldVld", int'(ISFITF_RdAddrVld), 1);
            chkD("addrHold", PW'(ISFITF_RdAddr), PW'(prevAddr));
        end
        prevStall = ISFITF_RdAddrVld && !ITFISF_RdAddrRdy;
        prevAddr  = ISFITF_RdAddr;
        if (ISFITF_RdAddrVld)
            chkI("reqAllowed", int'(!modelIdle && reqSeen < jobNum && (reqSeen - popSeen) < D), 1);
        if (ISFITF_RdAddrVld && ITFISF_RdAddrRdy) begin
            chkD("rdAddr", PW'(ISFITF_RdAddr), PW'(expAddr));
            expAddr = expAddr + 32'd1;
            pend.push_back('{ISFITF_RdAddr, cyc + lat});
            if (reqSeen == 0) firstReqCyc = cyc;
            reqSeen++;
        end
        if (ITFISF_RdDatVld) begin
            chkI("rdDatRdy", int'(ISFITF_RdDatRdy), 1);
            if (ISFITF_RdDatRdy) void'(pend.pop_front());
        end
        if (ISFCCU_ISARdDatVld && CCUISF_ISARdDatRdy) begin
            if (expQ.size() == 0) chkI("ccuExtraWord", 1, 0);
            else                  chkD("ccuDat", ISFCCU_ISARdDat, expQ.pop_front());
            if (popSeen == 0) firstPopCyc = cyc;
            popSeen++;
            lastPopCyc = cyc;
        end
        if (ISFTOP_Done) begin
            chkI("doneCount", popSeen, jobNum);
            chkI("doneQEmpty", expQ.size(), 0);
            doneSeen  = 1'b1;
            doneCyc   = cyc;
            modelIdle = 1'b1;
        end
        if (TOPISF_Start && wasIdle) begin
            modelIdle   = 1'b0;
            expAddr     = TOPISF_BaseAddr;
            jobNum      = int'(TOPISF_NumWord);
            reqSeen     = 0;
            popSeen     = 0;
            doneSeen    = 1'b0;
            startCyc    = cyc;
            firstReqCyc = -1;
            firstPopCyc = -1;
            for (int i = 0; i < jobNum; i++) expQ.push_back(wordOf(TOPISF_BaseAddr + 32'(i)));
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!doneSeen && n < budget) begin
            step();
            n++;
        end
        if (!doneSeen) chkI("doneTimeout", 0, 1);
    endtask

    task automatic launch(input logic [AW-1:0] base, input int num);
        startBase = base;
        startNum  = NW'(num);
        startNext = 1'b1;
        doneSeen  = 1'b0;
        step();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkI("rstVld", int'(ISFITF_RdAddrVld), 0);
        chkI("rstBusy", int'(ISFTOP_Busy), 0);
        chkI("rstDone", int'(ISFTOP_Done), 0);
        chkI("rstIsaVld", int'(ISFCCU_ISARdDatVld), 0);
        chkI("rstDatRdy", int'(ISFITF_RdDatRdy), 1);
        chkD("rstAddr", PW'(ISFITF_RdAddr), '0);
        pend.delete();
        expQ.delete();
        modelIdle = 1'b1;
        prevStall = 1'b0;
        startNext = 1'b0;
        noise     = 1'b0;
        jobNum    = 0;
        reqSeen   = 0;
        popSeen   = 0;
        TOPISF_Start    = 1'b0;
        ITFISF_RdDatVld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runJob(input job_t j);
        pA    = j.pA;
        pC    = j.pC;
        lat   = j.lat;
        noise = j.noise;
        launch(j.base, j.num);
        waitDone(4000);
        noise = 1'b0;
        if (j.num == 0) begin
            chkI("zeroLenDone", doneCyc - startCyc, 1);
            chkI("zeroLenReq", reqSeen, 0);
        end else begin
            chkI("reqTotal", reqSeen, j.num);
            if (j.pA == 100) chkI("firstReqLat", firstReqCyc - startCyc, 1);
            if (j.pA == 100 && j.pC == 100) begin
                chkI("firstWordLat", firstPopCyc - firstReqCyc, j.lat + 1);
                chkI("doneAfterPop", int'((doneCyc - lastPopCyc) >= 1 && (doneCyc - lastPopCyc) <= 2), 1);
            end
        end
        step();
    endtask

    initial begin
        TOPISF_Start       = 1'b0;
        TOPISF_BaseAddr    = '0;
        TOPISF_NumWord     = '0;
        ITFISF_RdAddrRdy   = 1'b0;
        ITFISF_RdDat       = '0;
        ITFISF_RdDatVld    = 1'b0;
        CCUISF_ISARdDatRdy = 1'b0;

        jobs[0] = '{32'h0000_0100, 4,  100, 100, 2, 1'b0};
        jobs[1] = '{32'h0000_0200, 0,  100, 100, 2, 1'b0};
        jobs[2] = '{32'hFFFF_FFFE, 4,  100, 100, 2, 1'b0};
        jobs[3] = '{32'h0000_2000, 50, 60,  50,  3, 1'b1};
        jobs[4] = '{32'h0000_0040, 9,  70,  100, 1, 1'b0};
        jobs[5] = '{32'h7FFF_FFF8, 16, 100, 30,  4, 1'b1};

        applyReset();
        for (int k = 0; k < 6; k++) runJob(jobs[k]);

        // Credit stall: CCU holds off, requests stop at D words with the buffer full.
        pA = 100; pC = 0; lat = 2;
        launch(32'h0000_3000, 20);
        repeat (25) step();
        chkI("stallReqs", reqSeen, D);
        chkI("stallVld", int'(ISFITF_RdAddrVld), 0);
        chkI("stallFull", int'(ISFITF_RdDatRdy), 0);
        chkI("stallHead", int'(ISFCCU_ISARdDatVld), 1);
        pC = 100;
        waitDone(500);
        chkI("stallTotal", reqSeen, 20);
        step();

        // Reset in the middle of FETCH, then a fresh short job.
        pA = 100; pC = 0; lat = 2;
        launch(32'h0000_4000, 10);
        for (int n = 0; n < 20 && reqSeen < 3; n++) step();
        chkI("midReqs", reqSeen, 3);
        applyReset();
        pA = 100; pC = 100;
        launch(32'h0000_5000, 2);
        waitDone(100);
        chkI("postRstReqs", reqSeen, 2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
